mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL expose parameter MULT_CYCLES, default 5, meaning the number of Busy cycles for MULT/MULTU (legal range 1..15).
REQ-002 SHALL expose parameter DIV_CYCLES, default 10, meaning the number of Busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  qualifies Op for one cycle.
REQ-006 Op  input  3  operation: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP.
REQ-007 A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source).
REQ-008 B  input  32  operand rt (divisor / multiplier).
REQ-009 ReadSel  input  1  0 selects LO, 1 selects HI onto Out.
REQ-010 Busy  output  1  high while a multiply/divide is in flight.
REQ-011 Out  output  32  combinational read of the HI or LO register per ReadSel.

Function
REQ-012 Out SHALL equal HI when ReadSel=1 and LO when ReadSel=0, purely combinationally from the registers, including while Busy=1.
REQ-013 The state machine SHALL have two states: IDLE (Busy=0) and RUN (Busy=1).
REQ-014 In IDLE, Start=1 with Op in {001..100} SHALL capture A, B, Op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN at that edge.
REQ-015 In RUN, the counter SHALL decrement each edge; on the edge where counter=1 the result SHALL be written to HI/LO and the state SHALL return to IDLE.
REQ-016 Busy SHALL therefore be high for exactly MULT_CYCLES (or DIV_CYCLES) cycles, starting the cycle after the Start edge; HI/LO SHALL hold new values in the first cycle Busy=0.
REQ-017 MULT: {HI,LO} SHALL equal the signed 64-bit product of captured A and B; MULTU: the unsigned 64-bit product.
REQ-018 DIV: LO SHALL equal the signed quotient truncated toward zero and HI the remainder, whose sign follows the dividend; DIVU: unsigned quotient and remainder.
REQ-019 DIV with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-020 DIV/DIVU with captured B=0 SHALL run the full DIV_CYCLES and leave HI and LO unchanged.
REQ-021 In IDLE, Start=1 with Op=101 SHALL write A to HI at that edge; Op=110 SHALL write A to LO; no Busy assertion.
REQ-022 Start=1 with any Op while in RUN SHALL be ignored entirely (no capture, no HI/LO write, counter unaffected).
REQ-023 Start=1 with Op=000 or 111 SHALL have no effect.
REQ-024 Changes on A, B or Op during RUN SHALL NOT affect the in-flight result (operands captured at Start).
REQ-025 Back-to-back: a Start in the first cycle Busy=0 after completion SHALL be accepted normally.

Reset
REQ-026 Reset low SHALL immediately (without Clk) force HI=0, LO=0, counter=0, state=IDLE, Busy=0; Out then reads 0.
REQ-027 Reset asserted during RUN SHALL abort the operation; no result SHALL be written after release.
REQ-028 While Reset is low, Start SHALL be ignored; the first edge with Reset high SHALL accept Start.

Verification
REQ-029 Reset low, then high; Start, Op=001, A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 Start, Op=010, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 Busy cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 Start, Op=011, A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; then Op=100, A=7, B=0 -> HI/LO unchanged after 10 cycles.
REQ-032 Start Op=001 A=2 B=3, then during Busy pulse Start with Op=101 A=0x1234 and change A/B -> ignored; final HI=0, LO=6.
REQ-033 Start Op=101 A=0xAAAA5555, next cycle Op=110 A=0x0F0F0F0F -> no Busy; ReadSel=1 gives 0xAAAA5555, ReadSel=0 gives 0x0F0F0F0F.
REQ-034 Start Op=100 A=100 B=7, assert Reset low mid-Busy (cycle 4) asynchronously -> Busy, HI, LO drop to 0 immediately and stay 0 after release.

Source files
------------

// File: rtl/mdu_if.sv
// Multiply/divide unit request/readback bundle.
//   Start   : qualifies Op for one cycle
//   Op      : 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP
//   A, B    : operands rs / rt
//   ReadSel : 0 reads LO, 1 reads HI onto Out
//   Busy    : high while a multiply/divide is in flight
//   Out     : combinational HI/LO read
interface mdu_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        ReadSel;
    logic        Busy;
    logic [31:0] Out;

    modport master (output Start, Op, A, B, ReadSel, input Busy, Out);
    modport slave  (input Start, Op, A, B, ReadSel, output Busy, Out);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle HI/LO multiply/divide unit.
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : mdu_if slave (Start/Op/A/B/ReadSel in, Busy/Out out)
// Operands are captured at Start; the result is written to HI/LO on the
// last Busy edge. Divide by zero runs the full latency and writes nothing.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic  Clk,
    input  logic  Reset,
    mdu_if.slave  bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [2:0]      op_q,    op_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic [W-1:0]    hi_q,    hi_d;
    logic [W-1:0]    lo_q,    lo_d;

    logic signed [2*W-1:0] mul_s;
    logic [2*W-1:0]        mul_u;
    logic                  is_signed_div;
    logic                  a_neg;
    logic                  b_neg;
    logic [W-1:0]          abs_a;
    logic [W-1:0]          abs_b;
    logic [W-1:0]          divisor;
    logic [W-1:0]          q_mag;
    logic [W-1:0]          r_mag;
    logic [W-1:0]          quot;
    logic [W-1:0]          rem;

    // Arithmetic on captured operands; only consumed on the final Busy edge.
    always_comb begin
        mul_s = $signed({{W{a_q[W-1]}}, a_q}) * $signed({{W{b_q[W-1]}}, b_q});
        mul_u = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

        // Signed divide via magnitudes: truncates toward zero, remainder takes
        // the dividend's sign, and 0x80000000 / -1 wraps to 0x80000000 naturally.
        is_signed_div = (op_q == OP_DIV);
        a_neg   = is_signed_div && a_q[W-1];
        b_neg   = is_signed_div && b_q[W-1];
        abs_a   = a_neg ? -a_q : a_q;
        abs_b   = b_neg ? -b_q : b_q;
        divisor = (b_q == '0) ? W'(1) : abs_b;
        q_mag   = abs_a / divisor;
        r_mag   = abs_a % divisor;
        quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
                        OP_MULT, OP_MULTU: begin
                            op_d    = bus.Op;
                            a_d     = bus.A;
                            b_d     = bus.B;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = bus.Op;
                            a_d     = bus.A;
                            b_d     = bus.B;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Start is ignored entirely here.
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = mul_s;
                        OP_MULTU: {hi_d, lo_d} = mul_u;
                        OP_DIV, OP_DIVU: begin
                            if (b_q != '0) begin
                                lo_d = quot;
                                hi_d = rem;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.Busy = (state_q == S_RUN);
    assign bus.Out  = bus.ReadSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the driver pushes expected HI/LO/Busy-length
// records; a negedge monitor pops one whenever Busy falls or the driver
// requests an idle check, then reads HI and LO through ReadSel.
module tb_mdu_unit;
    logic Clk;
    logic Reset;
    logic chk_req;

    mdu_if bus ();

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cmp(input string name, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, what, act, exp);
        end
    endtask

    // Monitor: counts Busy cycles and checks HI/LO at each completion or request.
    initial begin
        logic        prev_busy;
        logic        cur_busy;
        int          busy_cnt;
        exp_t        e;
        logic [31:0] hi;
        logic [31:0] lo;
        prev_busy = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge Clk);
            cur_busy = bus.Busy;
            if (cur_busy === 1'b1) busy_cnt++;
            if ((prev_busy && !cur_busy) || chk_req) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_event: got completion, expected none");
                end else begin
                    e = sb.pop_front();
                    bus.ReadSel = 1'b1;
                    #1 hi = bus.Out;
                    bus.ReadSel = 1'b0;
                    #1 lo = bus.Out;
                    cmp(e.name, "busy_cycles", 32'(busy_cnt), 32'(e.cycles));
                    cmp(e.name, "HI", hi, e.hi);
                    cmp(e.name, "LO", lo, e.lo);
                end
                busy_cnt = 0;
            end
            prev_busy = cur_busy;
        end
    end

    task automatic expect_op(input string name, input int cycles, input logic [31:0] hi,
                             input logic [31:0] lo);
        exp_t e;
        e.name = name; e.cycles = cycles; e.hi = hi; e.lo = lo;
        sb.push_back(e);
    endtask

    // Idle check: one-cycle request for the monitor.
    task automatic check_idle(input string name, input logic [31:0] hi, input logic [31:0] lo);
        expect_op(name, 0, hi, lo);
        chk_req = 1'b1;
        @(posedge Clk);
        #1 chk_req = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge Clk);
        #1 bus.Start = 1'b0;
    endtask

    // Returns in the first Busy=0 cycle after completion (bounded).
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge Clk);
            #1 n++;
        end while (bus.Busy === 1'b1 && n < 40);
        if (bus.Busy === 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s.timeout: got Busy=1 after %0d cycles, expected Busy=0", name, n);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles, input logic [31:0] hi,
                          input logic [31:0] lo);
        expect_op(name, cycles, hi, lo);
        issue(op, a, b);
        wait_idle(name);
    endtask

    initial begin
        chk_req     = 1'b0;
        bus.Start   = 1'b0;
        bus.Op      = 3'b000;
        bus.A       = '0;
        bus.B       = '0;
        bus.ReadSel = 1'b0;
        Reset       = 1'b1;
        #3 Reset = 1'b0;

        // Start held high during reset is ignored.
        bus.Start = 1'b1;
        bus.Op    = 3'b101;
        bus.A     = 32'hDEADBEEF;
        repeat (3) @(posedge Clk);
        #1;
        check_idle("reset_hold", 32'h0, 32'h0);

        // First edge with reset high accepts the pending MTHI.
        Reset = 1'b1;
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        check_idle("mthi_after_reset", 32'hDEADBEEF, 32'h0);

        // Back-to-back sequence: each op starts in the first idle cycle.
        run_op("mult_neg2x3",    3'b001, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu_max",      3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg7by2",    3'b011, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_by_zero",   3'b100, 32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_overflow",   3'b011, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_op("divu_100by7",    3'b100, 32'd100,      32'd7,        10, 32'd2,        32'd14);
        run_op("mult_neg5xneg7", 3'b001, 32'hFFFFFFFB, 32'hFFFFFFF9, 5,  32'h0,        32'd35);
        run_op("div_7byneg2",    3'b011, 32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD);

        // Start and operand changes while busy must not disturb the result.
        expect_op("mult_ignore", 5, 32'h0, 32'd6);
        issue(3'b001, 32'd2, 32'd3);
        @(posedge Clk);
        #1;
        issue(3'b101, 32'h00001234, 32'h55555555);
        issue(3'b011, 32'hCAFEF00D, 32'd9);
        bus.A = 32'h11111111;
        bus.B = 32'h22222222;
        wait_idle("mult_ignore");

        // MTHI then MTLO: no Busy, both registers written.
        issue(3'b101, 32'hAAAA5555, 32'h0);
        issue(3'b110, 32'h0F0F0F0F, 32'h0);
        check_idle("mthi_mtlo", 32'hAAAA5555, 32'h0F0F0F0F);

        // NOP encodings leave everything unchanged.
        issue(3'b000, 32'h12345678, 32'h9);
        issue(3'b111, 32'h87654321, 32'h9);
        check_idle("nop_ops", 32'hAAAA5555, 32'h0F0F0F0F);

        // Async reset during a divide: Busy falls in the 4th busy cycle,
        // so the monitor has sampled Busy high on 3 negedges.
        expect_op("reset_abort", 3, 32'h0, 32'h0);
        issue(3'b100, 32'd100, 32'd7);
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        repeat (15) @(posedge Clk);
        #1;
        check_idle("reset_stays_zero", 32'h0, 32'h0);

        // Drain the scoreboard.
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge Clk);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s.missing: got no completion, expected one", e.name);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
